// File: rtl/instr_encoder_pkg.sv
// Shared constants and types for the instruction encoder.
// Optional feature macro: IMM_RANGE_CHECK_EN (adds per-entry range error bit).
package instr_encoder_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FMT_I,
        FMT_S,
        FMT_SB
    } fmt_e;

`ifdef IMM_RANGE_CHECK_EN
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } fifo_entry_t;
`else
    typedef struct packed {
        logic [31:0] instr;
    } fifo_entry_t;
`endif

    // Anything that is not a known I or SB opcode is packed as a store.
    function automatic fmt_e fmt_of(input logic [6:0] opcode);
        fmt_e f;
        case (opcode)
            OP_IMM, OP_LOAD: f = FMT_I;
            OP_BRANCH:       f = FMT_SB;
            OP_STORE:        f = FMT_S;
            default:         f = FMT_S;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-set input, packed-instruction output and status signals of the encoder.
// Optional feature macro: IMM_RANGE_CHECK_EN (out_err/err_range become live).
interface instr_encoder_if;

    // Both channels: a transfer happens on a rising clk edge where valid && ready;
    // the producer holds its payload stable while valid && !ready.
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [63:0] in_imm;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_addr;
    logic        out_err;

    logic        err_range;
    logic [31:0] emit_count;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
        input  in_ready,
        input  out_valid, out_instr, out_addr, out_err,
        output out_ready,
        input  err_range, emit_count
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm,
        output in_ready,
        output out_valid, out_instr, out_addr, out_err,
        input  out_ready,
        output err_range, emit_count
    );

endinterface

// File: rtl/instr_encoder_imm_packer.sv
// Combinational packer: picks I/S/SB from the opcode and scatters fields and immediate.
// Optional feature macro: IMM_RANGE_CHECK_EN (adds the err output).
module imm_packer
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [63:0] imm,
`ifdef IMM_RANGE_CHECK_EN
    output logic        err,
`endif
    output logic [31:0] instr
);

    logic [11:0] imm12;
    fmt_e        fmt;

    assign imm12 = imm[11:0];
    assign fmt   = fmt_of(opcode);

    // SB keeps the halfword offset unshifted: imm[10] lands in bit 7, imm[9:4] in [30:25].
    always_comb begin
        instr        = '0;
        instr[6:0]   = opcode;
        instr[14:12] = funct3;
        case (fmt)
            FMT_I: begin
                instr[31:20] = imm12;
                instr[19:15] = rs1;
                instr[11:7]  = rd;
            end
            FMT_SB: begin
                instr[31]    = imm12[11];
                instr[30:25] = imm12[9:4];
                instr[24:20] = rs2;
                instr[19:15] = rs1;
                instr[11:8]  = imm12[3:0];
                instr[7]     = imm12[10];
            end
            default: begin
                instr[31:25] = imm12[11:5];
                instr[24:20] = rs2;
                instr[19:15] = rs1;
                instr[11:7]  = imm12[4:0];
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Legal 12-bit signed value: bits 63..11 are all copies of the sign.
    assign err = !((&imm[63:11]) || !(|imm[63:11]));
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[63:12];
`endif

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: packer feeding a small FIFO with a running byte address.
// Optional feature macro: IMM_RANGE_CHECK_EN (per-entry out_err and sticky err_range).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int          DEPTH     = 2
) (
    input logic            clk,
    input logic            reset,
    instr_encoder_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fifo_entry_t     mem [DEPTH];
    fifo_entry_t     new_entry;
    fifo_entry_t     head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     emit_count_q;
    logic [31:0]     packed_instr;
    logic            push;
    logic            pop;

`ifdef IMM_RANGE_CHECK_EN
    logic packed_err;
    logic err_range_q;
`endif

    imm_packer u_packer (
        .opcode (bus.in_opcode),
        .rd     (bus.in_rd),
        .rs1    (bus.in_rs1),
        .rs2    (bus.in_rs2),
        .funct3 (bus.in_funct3),
        .imm    (bus.in_imm),
`ifdef IMM_RANGE_CHECK_EN
        .err    (packed_err),
`endif
        .instr  (packed_instr)
    );

    always_comb begin
        new_entry       = '0;
        new_entry.instr = packed_instr;
`ifdef IMM_RANGE_CHECK_EN
        new_entry.err   = packed_err;
`endif
    end

    // in_ready looks only at registered occupancy; a full buffer never accepts
    // even when the head is popped in the same cycle.
    assign bus.in_ready  = (count < CW'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign head          = mem[rd_ptr];

    assign bus.out_instr  = bus.out_valid ? head.instr : 32'd0;
    assign bus.emit_count = emit_count_q;
    assign bus.out_addr   = BASE_ADDR + 64'(emit_count_q) * 64'(INSTR_BYTES);

`ifdef IMM_RANGE_CHECK_EN
    assign bus.out_err   = bus.out_valid && head.err;
    assign bus.err_range = err_range_q;
`else
    assign bus.out_err   = 1'b0;
    assign bus.err_range = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            emit_count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                emit_count_q <= emit_count_q + 32'd1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_range_q <= 1'b0;
        end else if (push && packed_err) begin
            err_range_q <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the core's immediate extraction. Accepts decoded instruction fields plus a 64-bit sign-extended immediate and packs them into a 32-bit RV64 instruction word (I-, S- or SB-type). Results pass through a 2-entry output buffer with a running instruction-memory byte address. Used by the program loader and the self-test generator to build instruction images that the decode path then reads back.

## Interface
Parameters:
- BASE_ADDR, 64'd0: byte address assigned to the first emitted instruction.
- DEPTH, 2: output buffer entries. Legal values are 2 and 4.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  field set present.
- in_ready  out  1  field set accepted when in_valid && in_ready.
- in_opcode  in  7  opcode; also selects the format.
- in_rd  in  5  destination register (I only).
- in_rs1  in  5  source 1.
- in_rs2  in  5  source 2 (S/SB only).
- in_funct3  in  3  funct3.
- in_imm  in  64  sign-extended immediate.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer takes head when out_valid && out_ready.
- out_instr  out  32  packed instruction.
- out_addr  out  64  byte address of out_instr.
- out_err  out  1  head entry had an out-of-range immediate.
- err_range  out  1  sticky range-error flag.
- emit_count  out  32  instructions popped since reset.

## Operation
- Format select from in_opcode:
  - 0010011 or 0000011 → I.
  - 1100011 → SB.
  - Any other value → S.
- Packing; bits [6:0] are always the opcode, [14:12] are always funct3:
  - I: [31:20]=imm[11:0], [19:15]=rs1, [11:7]=rd.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [11:7]=imm[4:0].
  - SB: [31]=imm[11], [30:25]=imm[9:4], [24:20]=rs2, [19:15]=rs1, [11:8]=imm[3:0], [7]=imm[10]. The immediate is a halfword offset and is not shifted.
- Range rule: the immediate is legal iff in_imm[63:11] are all equal (12-bit signed). An illegal value is truncated to imm[11:0] and the entry's err bit is set.
- Buffer: DEPTH-entry FIFO of {instr, err}.
  - in_ready = (count < DEPTH). It depends only on registered state; there is no same-cycle bypass when full.
  - A simultaneous push and pop with 0 < count < DEPTH leaves count unchanged.
- Address:
  - out_addr = BASE_ADDR + 4·emit_count, modulo 2^64. It wraps silently.
  - emit_count increments on each pop and wraps at 2^32.
- err_range is set by any push whose err bit is 1. It is cleared only by reset.

## Timing
- Latency: a field set pushed at edge N is visible on out_* after edge N, provided the buffer was empty.
- Throughput: one instruction per cycle while out_ready stays high.
- out_* hold steady while out_valid && !out_ready.
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_err=0, err_range=0, emit_count=0, out_addr=BASE_ADDR.
- Reset asserted mid-stream flushes all buffered entries in that cycle. Any handshake in the same cycle is ignored.

## Configuration
- IMM_RANGE_CHECK_EN defined: range checking as described above.
- IMM_RANGE_CHECK_EN undefined:
  - No range check. The immediate is truncated silently.
  - out_err and err_range are tied to 0.
  - The FIFO entry drops the err bit.

## Structure
- Shared package contents:
  - Opcode constants: OP_IMM=7'b0010011, OP_LOAD=7'b0000011, OP_BRANCH=7'b1100011, OP_STORE=7'b0100011.
  - Format enum {FMT_I, FMT_S, FMT_SB}.
  - Constant INSTR_BYTES=4.
- One combinational sub-module, imm_packer, covering format select, field packing and the range check. The top level holds the FIFO, counter and flags.

## Test plan
- I-type addi: opcode 0010011, rd=1, rs1=2, funct3=0, imm=64'hFFFF_FFFF_FFFF_FFFF → out_instr=32'hFFF10093, out_addr=BASE_ADDR, out_err=0.
- Load ld: opcode 0000011, rd=5, rs1=6, funct3=3, imm=8 → 32'h00833283. Store sd: opcode 0100011, rs1=8, rs2=7, funct3=3, imm=16 → 32'h00743823.
- SB-type beq: opcode 1100011, rs1=1, rs2=2, funct3=0, imm=4 → 32'h00208463. Round trip through the core's immediate decoder returns imm=4.
- Range error with IMM_RANGE_CHECK_EN: I-type imm=2048 → imm field 12'h800, out_err=1, err_range stays 1 after the entry pops. Without the macro → out_err=0, err_range=0.
- Backpressure: out_ready=0 while pushing 3 field sets → in_ready falls after the 2nd push and the head holds steady. Raising out_ready → 3 instructions emitted in order with addresses BASE_ADDR, +4, +8, and emit_count=3.
- Reset mid-stream with 2 entries buffered → next cycle shows out_valid=0, in_ready=1, emit_count=0, out_addr=BASE_ADDR.
